div_result_collector: RTL
=========================

// Module: div_result_collector
// PURPOSE
//   Sits directly downstream of the pipelined DIV block.
//   Tracks which DIV pipeline slots hold real operations with a valid delay line matched to the DIV latency.
//   Captures the quotient and sticky remainder of each valid slot into a show-ahead FIFO with a valid/ready output.
//   Issues credits upstream: DIV cannot stall, so the FIFO can never overflow.
// PARAMETERS
//   S      5  DIV stage count; quotient width is S+1.
//   LAT    5  cycles from operands at DIV inputs to C/REM at DIV outputs; must equal DIV latency (= S).
//   DEPTH  4  result FIFO entries, also total credit pool; >= 2.
// PORTS
//   CLK          in   1    clock, all state on posedge
//   RSTN         in   1    async active-low reset
//   IN_VALID     in   1    upstream presents a real operand pair to DIV this cycle
//   IN_DIVZ      in   1    denominator of that pair is zero (qualified by IN_VALID)
//   ISSUE_READY  out  1    credit available; an issue is accepted only when IN_VALID & ISSUE_READY
//   ISSUE_DROP   out  1    1-cycle pulse: IN_VALID while !ISSUE_READY (operation not tracked)
//   C_I          in   S+1  DIV quotient output
//   REM_I        in   1    DIV nonzero-remainder flag
//   OUT_VALID    out  1    FIFO non-empty; head entry presented on Q_O/DIVZ_O/INEXACT_O
//   OUT_READY    in   1    consumer accepts head when OUT_VALID & OUT_READY
//   Q_O          out  S+1  head quotient
//   DIVZ_O       out  1    head entry was divide-by-zero
//   INEXACT_O    out  1    head entry had nonzero remainder
//   USED_O       out  clog2(DEPTH+1)  in-flight + queued count (debug)
// BEHAVIOUR
//   Reset (async, RSTN=0): delay line, FIFO pointers, and used count clear.
//     OUT_VALID=0, Q_O=0, DIVZ_O=0, INEXACT_O=0, ISSUE_DROP=0, USED_O=0, ISSUE_READY=1.
//     In-flight operations are discarded; DIV shares RSTN, so its pipeline is consistent with this.
//   issue = IN_VALID & ISSUE_READY.
//     LAT-deep shift register of {valid, divz} loads {issue, IN_DIVZ & issue} every cycle.
//     Its tail aligns exactly with C_I/REM_I of the same operation.
//   push = tail.valid.
//     On push the FIFO writes:
//       Q = tail.divz ? all-ones : C_I
//       DIVZ = tail.divz
//       INEXACT = tail.divz ? 0 : REM_I
//     C_I/REM_I are ignored in cycles where tail.valid=0.
//   pop = OUT_VALID & OUT_READY; the head advances on the next edge.
//     Show-ahead: outputs are registered FIFO head, no combinational path from inputs.
//     Outputs hold stable while OUT_VALID & !OUT_READY.
//   Credits: used += issue, used -= pop.
//     Simultaneous issue and pop leaves used unchanged.
//     ISSUE_READY = (used < DEPTH), registered-state based, no combinational dependence on IN_VALID.
//   Invariant: used = in-flight valid slots + FIFO occupancy <= DEPTH, so push into a full FIFO is impossible.
//     Bench asserts it; RTL need not guard.
//   Simultaneous push and pop (including FIFO at 1 or DEPTH entries) is legal; occupancy is unchanged.
//   Pop while empty cannot occur (OUT_VALID=0). OUT_READY while empty is ignored.
//   Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
//   ISSUE_DROP is registered: asserted the cycle after a rejected IN_VALID.
//   IN_DIVZ is ignored when the issue is not accepted.
//   Latency: issue at cycle t -> OUT_VALID at t+LAT+1 if FIFO was empty.
// TESTING (bench models DIV as an LAT-cycle delay of driven C_I/REM_I)
//   Single op: issue at t0, C_I=6'd6, REM_I=0 at t0+5.
//     -> OUT_VALID at t0+6, Q_O=6, INEXACT_O=0, USED_O 1 -> 0 after pop.
//   Divide by zero: issue with IN_DIVZ=1, C_I=6'd13, REM_I=1 at tail.
//     -> Q_O=6'h3F, DIVZ_O=1, INEXACT_O=0.
//   Backpressure: OUT_READY=0, issue every cycle.
//     -> 4 accepted, ISSUE_READY=0 from 5th cycle.
//     -> ISSUE_DROP pulses for the rejected 5th.
//     -> FIFO fills to 4, Q_O holds the first result.
//   Full throughput: OUT_READY=1, IN_VALID=1 for 20 cycles.
//     -> 20 results in issue order, no drops, USED_O steady at LAT+1 <= DEPTH requires DEPTH>=6.
//     -> rerun at DEPTH=6 to confirm.
//   Bubbles: issue pattern 1,0,1,1,0 with distinct C_I.
//     -> only the 3 valid results queued, in order, with matching INEXACT_O.
//   Reset mid-flight: 3 ops in flight plus 2 queued, pulse RSTN low between edges.
//     -> all outputs 0 immediately, ISSUE_READY=1.
//     -> no stale results after release.

Source files
------------

// File: rtl/div_result_collector.sv
// ---------------------------------------------------------------------------
// div_result_collector
//
// Purpose:
//   Sits directly downstream of a pipelined divider that cannot stall. A
//   LAT-deep delay line of {valid, divz} marks which divider slots carry real
//   operations. When an operation reaches the tail, its quotient and sticky
//   remainder are written into a small show-ahead result FIFO. Upstream issue
//   is gated by a credit pool of DEPTH entries, which covers both in-flight
//   slots and queued results, so the FIFO can never overflow.
//
// Handshakes:
//   Issue side : an operation is accepted when IN_VALID & ISSUE_READY.
//                ISSUE_READY depends only on registered state. A request made
//                while ISSUE_READY=0 is dropped and reported one cycle later
//                on ISSUE_DROP.
//   Output side: the head entry transfers when OUT_VALID & OUT_READY. The
//                head advances on that edge. While OUT_VALID & !OUT_READY the
//                outputs hold steady. OUT_READY with OUT_VALID=0 is ignored.
//
// Ports:
//   CLK, RSTN        clock (posedge) and asynchronous active-low reset
//   IN_VALID         upstream presents an operand pair to the divider
//   IN_DIVZ          that pair has a zero denominator
//   ISSUE_READY      a credit is available
//   ISSUE_DROP       registered pulse: the previous cycle's IN_VALID was dropped
//   C_I, REM_I       divider quotient and nonzero-remainder flag (tail aligned)
//   OUT_VALID        result FIFO is non-empty
//   OUT_READY        consumer accepts the head entry
//   Q_O              head quotient (all ones for divide-by-zero)
//   DIVZ_O           head entry was a divide-by-zero
//   INEXACT_O        head entry had a nonzero remainder
//   USED_O           in-flight plus queued operations (debug)
// ---------------------------------------------------------------------------
module div_result_collector #(
    parameter int S     = 5,
    parameter int LAT   = 5,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       IN_VALID,
    input  logic                       IN_DIVZ,
    output logic                       ISSUE_READY,
    output logic                       ISSUE_DROP,
    input  logic [S:0]                 C_I,
    input  logic                       REM_I,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [S:0]                 Q_O,
    output logic                       DIVZ_O,
    output logic                       INEXACT_O,
    output logic [$clog2(DEPTH+1)-1:0] USED_O
);

    localparam int UW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    // FIFO entry layout: {divz, inexact, quotient[S:0]}
    localparam int EW = S + 3;

    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] dz_q, dz_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]  cnt_q, cnt_d;
    logic [UW-1:0]  used_q, used_d;
    logic           drop_q, drop_d;

    logic           issue;
    logic           push;
    logic           pop;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  head;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ISSUE_READY = (used_q < UW'(DEPTH));
    assign OUT_VALID   = (cnt_q != '0);
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        issue    = IN_VALID & ISSUE_READY;
        push     = vld_q[LAT-1];
        pop      = OUT_VALID & OUT_READY;

        // Stage 0 receives the operation presented this cycle; the tail
        // (stage LAT-1) lines up with C_I/REM_I of that same operation.
        vld_d    = '0;
        dz_d     = '0;
        vld_d[0] = issue;
        dz_d[0]  = IN_DIVZ & issue;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dz_d[i]  = dz_q[i-1];
        end

        // Divide-by-zero forces an all-ones quotient and suppresses the
        // remainder flag, whatever the divider produced.
        if (dz_q[LAT-1]) begin
            wr_entry = {1'b1, 1'b0, {(S+1){1'b1}}};
        end else begin
            wr_entry = {1'b0, REM_I, C_I};
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q  + UW'(push)  - UW'(pop);
        // A credit is held from issue until the result leaves the FIFO.
        used_d   = used_q + UW'(issue) - UW'(pop);
        drop_d   = IN_VALID & ~ISSUE_READY;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q    <= '0;
            dz_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            used_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            dz_q     <= dz_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            used_q   <= used_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head fields are gated so an empty FIFO presents zeros.
    assign Q_O        = OUT_VALID ? head[S:0]   : '0;
    assign INEXACT_O  = OUT_VALID ? head[S+1]   : 1'b0;
    assign DIVZ_O     = OUT_VALID ? head[S+2]   : 1'b0;
    assign ISSUE_DROP = drop_q;
    assign USED_O     = used_q;

endmodule
